// File: rtl/matrix_mult.sv
// 4x4 by 4-vector binary32 product using one multiplier and one adder, stepped one term per cycle.
// Latency 16 cycles from acceptance to the valid_out pulse. No backpressure: requests arriving while busy are dropped.
module matrix_mult (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   valid_in,
   input  logic [3:0][3:0][31:0]  mat1_in,
   input  logic [3:0][31:0]       mat2_in,
   output logic                   valid_out,
   output logic [3:0][31:0]       mat_out
);

   localparam logic STATE_IDLE = 1'b0;
   localparam logic STATE_BUSY = 1'b1;
   localparam logic [31:0] QNAN = 32'h7FC00000;

   logic                  r_state;
   logic [3:0]            r_k;
   logic [31:0]           r_acc;
   logic [3:0][3:0][31:0] r_m1;
   logic [3:0][31:0]      r_m2;
   logic                  r_valid;
   logic [3:0][31:0]      r_out;

   logic [1:0]            w_row;
   logic [1:0]            w_col;
   logic [31:0]           w_prod;
   logic [31:0]           w_sum;

   // Rounding is done at full precision first; anything whose final exponent is below 1 flushes to signed zero.
   function automatic logic [31:0] fp_round(input logic s, input logic signed [10:0] ex_in,
                                            input logic [22:0] frac, input logic g, input logic st);
      logic [24:0]        m;
      logic signed [10:0] ex;
      m  = {2'b01, frac} + {24'h0, g & (st | frac[0])};
      ex = ex_in;
      if (m[24]) ex = ex + 11'sd1;
      if (ex >= 11'sd255) return {s, 8'hFF, 23'h0};
      if (ex <= 11'sd0) return {s, 31'h0};
      return {s, ex[7:0], (m[24] ? m[23:1] : m[22:0])};
   endfunction

   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic               s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic [47:0]        prod;
      logic signed [10:0] ex;
      s      = a[31] ^ b[31];
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
      a_zero = (a[30:23] == 8'h00);
      b_zero = (b[30:23] == 8'h00);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
      if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
      if (a_zero || b_zero) return {s, 31'h0};
      prod = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      ex   = $signed({3'b0, a[30:23]}) + $signed({3'b0, b[30:23]}) - 11'sd127;
      if (prod[47])
         return fp_round(s, ex + 11'sd1, prod[46:24], prod[23], |prod[22:0]);
      return fp_round(s, ex, prod[45:23], prod[22], |prod[21:0]);
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]        x, y;
      logic [7:0]         d;
      logic [50:0]        xw, yw, ysh, sum;
      logic [49:0]        norm;
      logic [5:0]         pos;
      logic signed [10:0] ex;
      logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
      a_zero = (a[30:23] == 8'h00);
      b_zero = (b[30:23] == 8'h00);
      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return QNAN;
      if (a_inf) return {a[31], 8'hFF, 23'h0};
      if (b_inf) return {b[31], 8'hFF, 23'h0};
      if (a_zero && b_zero) return {a[31] & b[31], 31'h0};
      if (a_zero) return b;
      if (b_zero) return a;
      if (a[30:0] < b[30:0]) begin
         x = b; y = a;
      end else begin
         x = a; y = b;
      end
      d  = x[30:23] - y[30:23];
      xw = {2'b01, x[22:0], 26'h0};
      yw = {2'b01, y[22:0], 26'h0};
      // 26 spare low bits keep guard/round exact; anything shifted further collapses into a sticky LSB.
      if (d > 8'd49) begin
         ysh = 51'd1;
      end else begin
         ysh    = yw >> d;
         ysh[0] = ysh[0] | (|(yw & ((51'd1 << d) - 51'd1)));
      end
      sum = (x[31] == y[31]) ? (xw + ysh) : (xw - ysh);
      if (sum == 51'h0) return 32'h0;
      pos = 6'd0;
      for (int i = 0; i < 51; i++)
         if (sum[i]) pos = 6'(i);
      norm = sum[49:0] << (6'd50 - pos);
      ex   = $signed({3'b0, x[30:23]}) + $signed({5'b0, pos}) - 11'sd49;
      return fp_round(x[31], ex, norm[49:27], norm[26], |norm[25:0]);
   endfunction

   always_comb begin
      w_row  = r_k[3:2];
      w_col  = r_k[1:0];
      w_prod = fp_mul(r_m1[w_row][w_col], r_m2[w_col]);
      w_sum  = (w_col == 2'd0) ? w_prod : fp_add(r_acc, w_prod);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= STATE_IDLE;
         r_k     <= 4'd0;
         r_acc   <= 32'h0;
         r_m1    <= '0;
         r_m2    <= '0;
         r_valid <= 1'b0;
         r_out   <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            STATE_IDLE: begin
               if (valid_in) begin
                  r_m1    <= mat1_in;
                  r_m2    <= mat2_in;
                  r_acc   <= 32'h0;
                  r_k     <= 4'd0;
                  r_state <= STATE_BUSY;
               end
            end
            default: begin
               r_acc <= w_sum;
               r_k   <= r_k + 4'd1;
               if (w_col == 2'd3) r_out[w_row] <= w_sum;
               if (r_k == 4'd15) begin
                  r_state <= STATE_IDLE;
                  r_valid <= 1'b1;
               end
            end
         endcase
      end
   end

   assign valid_out = r_valid;
   assign mat_out   = r_out;

endmodule

// File: tb/tb_matrix_mult.sv
// Bench for matrix_mult: directed cases plus randomized operands checked against a real-arithmetic model.
module tb_matrix_mult;

   typedef logic [3:0][3:0][31:0] mat_t;
   typedef logic [3:0][31:0]      vec_t;

   logic clk_in = 1'b0;
   logic rst_in;
   logic valid_in;
   mat_t mat1_in;
   vec_t mat2_in;
   logic valid_out;
   vec_t mat_out;

   int n_chk  = 0;
   int n_pass = 0;

   matrix_mult dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .valid_in  (valid_in),
      .mat1_in   (mat1_in),
      .mat2_in   (mat2_in),
      .valid_out (valid_out),
      .mat_out   (mat_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   // binary32 -> double with subnormal inputs read as signed zero
   function automatic real f2r(input logic [31:0] f);
      if (f[30:23] == 8'h00) return $bitstoreal({f[31], 63'h0});
      if (f[30:23] == 8'hFF)
         return (f[22:0] != 23'h0) ? $bitstoreal(64'h7FF8000000000000)
                                   : $bitstoreal({f[31], 11'h7FF, 52'h0});
      return $bitstoreal({f[31], 11'({3'b0, f[30:23]} + 11'd896), f[22:0], 29'h0});
   endfunction

   // double -> binary32, nearest-even, overflow to Inf, tiny results to signed zero
   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [24:0] m;
      int          e;
      d = $realtobits(r);
      if (d[62:52] == 11'h7FF) return (d[51:0] != 52'h0) ? 32'h7FC00000 : {d[63], 8'hFF, 23'h0};
      if (d[62:52] == 11'h000) return {d[63], 31'h0};
      m = {2'b01, d[51:29]} + {24'h0, d[28] & ((|d[27:0]) | d[29])};
      e = int'(d[62:52]) - 896;
      if (m[24]) begin
         e++;
         m = m >> 1;
      end
      if (e >= 255) return {d[63], 8'hFF, 23'h0};
      if (e <= 0) return {d[63], 31'h0};
      return {d[63], e[7:0], m[22:0]};
   endfunction

   function automatic vec_t ref_mv(input mat_t m, input vec_t v);
      vec_t        res;
      logic [31:0] acc, p;
      acc = 32'h0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            p   = r2f(f2r(m[i][j]) * f2r(v[j]));
            acc = (j == 0) ? p : r2f(f2r(acc) + f2r(p));
         end
         res[i] = acc;
      end
      return res;
   endfunction

   function automatic logic [31:0] rand_f();
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 60) return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
      if (sel < 85) return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      case ($urandom_range(0, 5))
         0:       return 32'h00000000;
         1:       return 32'h80000000;
         2:       return 32'h7F800000;
         3:       return 32'hFF800000;
         4:       return 32'h7FC00001;
         default: return 32'h00000123;
      endcase
   endfunction

   function automatic mat_t rand_mat();
      mat_t m;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) m[i][j] = rand_f();
      return m;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int j = 0; j < 4; j++) v[j] = rand_f();
      return v;
   endfunction

   // One request; inputs are scrambled right after acceptance to show the result only uses the captured copy.
   task automatic run_op(input string tag, input mat_t m1, input vec_t v, input vec_t exp_v);
      int lat;
      @(negedge clk_in);
      mat1_in  = m1;
      mat2_in  = v;
      valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      mat1_in  = rand_mat();
      mat2_in  = rand_vec();
      lat      = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk_in);
         #1;
         if (valid_out) begin
            lat = n;
            break;
         end
      end
      chk($sformatf("%s latency", tag), 32'(lat), 32'd16);
      for (int i = 0; i < 4; i++) chk($sformatf("%s row%0d", tag, i), mat_out[i], exp_v[i]);
      @(posedge clk_in);
      #1;
      chk($sformatf("%s pulse width", tag), 32'(valid_out), 32'd0);
   endtask

   initial begin
      mat_t m, m_b;
      vec_t v, v_b, e, e_b;
      int   pulses, first, second;

      rst_in   = 1'b1;
      valid_in = 1'b0;
      mat1_in  = '0;
      mat2_in  = '0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      chk("reset valid_out", 32'(valid_out), 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("reset row%0d", i), mat_out[i], 32'h0);

      m = '0;
      for (int i = 0; i < 4; i++) m[i][i] = 32'h3F800000;
      v = {4{32'h3F800000}};
      run_op("identity", m, v, {4{32'h3F800000}});

      m[0] = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
      m[1] = {32'h41000000, 32'h40C00000, 32'h40800000, 32'h40000000};
      m[2] = {32'h41400000, 32'h41100000, 32'h40C00000, 32'h40400000};
      m[3] = {32'h41800000, 32'h41400000, 32'h41000000, 32'h40800000};
      run_op("general", m, v, {32'h42200000, 32'h41F00000, 32'h41A00000, 32'h41200000});

      // element j of a row is bits [j*32 +: 32], so literal lists run from column 3 down to column 0
      m    = '0;
      m[0] = {32'h0, 32'h0, 32'hC0000000, 32'h40000000};
      m[1] = {32'h0, 32'h0, 32'h0, 32'hBF800000};
      v    = {32'h3F800000, 32'h3F800000, 32'h40400000, 32'h40400000};
      run_op("cancel", m, v, {32'h0, 32'h0, 32'hC0400000, 32'h0});

      m    = '0;
      m[0] = {32'h0, 32'h0, 32'h7F000000, 32'h7F000000};
      m[1] = {32'h0, 32'h7F800000, 32'h0, 32'h0};
      v    = {32'h3F800000, 32'h0, 32'h40000000, 32'h40000000};
      run_op("specials", m, v, {32'h0, 32'h0, 32'h7FC00000, 32'h7F800000});

      // second request at E5 while busy
      m = rand_mat(); v = rand_vec(); e = ref_mv(m, v);
      @(negedge clk_in);
      mat1_in = m; mat2_in = v; valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      pulses = 0; first = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk_in);
         #1;
         if (n == 4) begin
            mat1_in = rand_mat(); mat2_in = rand_vec(); valid_in = 1'b1;
         end
         if (n == 5) valid_in = 1'b0;
         if (valid_out) begin
            pulses++;
            if (pulses == 1) begin
               first = n;
               for (int i = 0; i < 4; i++) chk($sformatf("busy row%0d", i), mat_out[i], e[i]);
            end
         end
      end
      chk("busy pulses", 32'(pulses), 32'd1);
      chk("busy latency", 32'(first), 32'd16);

      // valid_in held high: accepts at E0 and E17
      m   = rand_mat(); v   = rand_vec(); e   = ref_mv(m, v);
      m_b = rand_mat(); v_b = rand_vec(); e_b = ref_mv(m_b, v_b);
      @(negedge clk_in);
      mat1_in = m; mat2_in = v; valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      mat1_in = m_b; mat2_in = v_b;
      pulses = 0; first = 0; second = 0;
      for (int n = 1; n <= 45; n++) begin
         @(posedge clk_in);
         #1;
         if (n == 17) begin
            valid_in = 1'b0; mat1_in = rand_mat(); mat2_in = rand_vec();
         end
         if (valid_out) begin
            pulses++;
            if (pulses == 1) begin
               first = n;
               for (int i = 0; i < 4; i++) chk($sformatf("b2b first row%0d", i), mat_out[i], e[i]);
            end else if (pulses == 2) begin
               second = n;
               for (int i = 0; i < 4; i++) chk($sformatf("b2b second row%0d", i), mat_out[i], e_b[i]);
            end
         end
      end
      chk("b2b pulses", 32'(pulses), 32'd2);
      chk("b2b first time", 32'(first), 32'd16);
      chk("b2b second time", 32'(second), 32'd33);

      // reset sampled at E8 aborts the operation
      m = '0;
      for (int i = 0; i < 4; i++) m[i][i] = 32'h40000000;
      @(negedge clk_in);
      mat1_in = m; mat2_in = {4{32'h3F800000}}; valid_in = 1'b1;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      pulses = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk_in);
         #1;
         if (n == 7) rst_in = 1'b1;
         if (n == 8) rst_in = 1'b0;
         if (valid_out) pulses++;
      end
      chk("abort pulses", 32'(pulses), 32'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("abort row%0d", i), mat_out[i], 32'h0);

      for (int t = 0; t < 20; t++) begin
         m = rand_mat();
         v = rand_vec();
         run_op($sformatf("rand%0d", t), m, v, ref_mv(m, v));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
